lcd_sequencer: RTL and testbench

Upstream companion of the LCD byte driver: performs the HD44780 4-bit power-on initialisation, then renders a 16-bit CPU value as "VAL:hhhh" on line 1. Emits one byte per transfer over the driver's data_in/data_valid/is_cmd/ready handshake. Sits between the CPU debug/output register and the LCD driver.

---
 rtl/lcd_sequencer_if.sv | 29 ++
 rtl/lcd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_sequencer_if.sv
// Byte handshake between the LCD sequencer and the LCD byte driver.
//   lcd_data_in    : byte to the driver
//   lcd_data_valid : one-cycle transfer strobe
//   lcd_is_cmd     : 1 = command byte, 0 = character byte
//   lcd_clear      : dedicated clear request (unused by the sequencer, held 0)
//   lcd_ready      : driver ready level (low while the driver works on a byte)
interface lcd_sequencer_if;
  logic [7:0] lcd_data_in;
  logic       lcd_data_valid;
  logic       lcd_is_cmd;
  logic       lcd_clear;
  logic       lcd_ready;

  modport master (
    output lcd_data_in,
    output lcd_data_valid,
    output lcd_is_cmd,
    output lcd_clear,
    input  lcd_ready
  );

  modport slave (
    input  lcd_data_in,
    input  lcd_data_valid,
    input  lcd_is_cmd,
    input  lcd_clear,
    output lcd_ready
  );
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: runs the HD44780 4-bit power-on initialisation, then renders
// a 16-bit value as "VAL:hhhh" on line 1, one byte per driver transfer.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   value      : value to display, latched at frame start
//   update     : one-cycle refresh request
//   busy       : high during init or while a frame is being sent
//   init_done  : high once the init sequence has completed
//   lcd        : byte handshake to the LCD driver (master side)
module lcd_sequencer #(
  parameter int unsigned INIT_DELAY  = 750000,
  parameter int unsigned CLEAR_DELAY = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        value,
  input  logic               update,
  output logic               busy,
  output logic               init_done,
  lcd_sequencer_if.master    lcd
);

  typedef enum logic [2:0] {
    POWER_WAIT,
    ISSUE,
    ACK,
    DONE,
    CLR_WAIT,
    IDLE
  } state_t;

  localparam logic [23:0] INIT_LAST  = 24'(INIT_DELAY - 1);
  localparam logic [23:0] CLEAR_LAST = 24'(CLEAR_DELAY - 1);
  localparam logic [3:0]  STEP_LAST_INIT  = 4'd5;
  localparam logic [3:0]  STEP_FRAME      = 4'd6;
  localparam logic [3:0]  STEP_LAST_FRAME = 4'd14;

  state_t      state, state_n;
  logic [3:0]  step, step_n;
  logic [23:0] counter, counter_n;
  logic [15:0] value_q, value_q_n;
  logic        pending, pending_n;
  logic        init_done_n;
  logic        busy_n;
  logic [7:0]  data_q, data_n;
  logic        valid_q, valid_n;
  logic        is_cmd_q, is_cmd_n;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // {is_cmd, byte} for a given step; digits come from the latched value.
  function automatic logic [8:0] step_byte(input logic [3:0] s, input logic [15:0] v);
    logic [8:0] b;
    case (s)
      4'd0:    b = {1'b1, 8'h33};
      4'd1:    b = {1'b1, 8'h32};
      4'd2:    b = {1'b1, 8'h28};
      4'd3:    b = {1'b1, 8'h0C};
      4'd4:    b = {1'b1, 8'h06};
      4'd5:    b = {1'b1, 8'h01};
      4'd6:    b = {1'b1, 8'h80};
      4'd7:    b = {1'b0, 8'h56};
      4'd8:    b = {1'b0, 8'h41};
      4'd9:    b = {1'b0, 8'h4C};
      4'd10:   b = {1'b0, 8'h3A};
      4'd11:   b = {1'b0, hex_ascii(v[15:12])};
      4'd12:   b = {1'b0, hex_ascii(v[11:8])};
      4'd13:   b = {1'b0, hex_ascii(v[7:4])};
      default: b = {1'b0, hex_ascii(v[3:0])};
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= POWER_WAIT;
      step      <= '0;
      counter   <= '0;
      value_q   <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      is_cmd_q  <= 1'b1;
    end else begin
      state     <= state_n;
      step      <= step_n;
      counter   <= counter_n;
      value_q   <= value_q_n;
      pending   <= pending_n;
      init_done <= init_done_n;
      busy      <= busy_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      is_cmd_q  <= is_cmd_n;
    end
  end

  always_comb begin
    state_n     = state;
    step_n      = step;
    counter_n   = counter;
    value_q_n   = value_q;
    pending_n   = pending;
    init_done_n = init_done;
    busy_n      = busy;
    data_n      = data_q;
    is_cmd_n    = is_cmd_q;
    valid_n     = 1'b0;

    // Requests outside IDLE collapse into a single pending frame.
    if (update && (state != IDLE)) begin
      pending_n = 1'b1;
    end

    case (state)
      POWER_WAIT: begin
        if (counter == INIT_LAST) begin
          counter_n = '0;
          step_n    = '0;
          state_n   = ISSUE;
        end else begin
          counter_n = counter + 24'd1;
        end
      end
      ISSUE: begin
        if (lcd.lcd_ready) begin
          {is_cmd_n, data_n} = step_byte(step, value_q);
          valid_n            = 1'b1;
          state_n            = ACK;
        end
      end
      ACK: begin
        if (!lcd.lcd_ready) begin
          state_n = DONE;
        end
      end
      DONE: begin
        // Data and is_cmd stay put until here; the driver samples is_cmd late.
        if (lcd.lcd_ready) begin
          if (step == STEP_LAST_INIT) begin
            counter_n = '0;
            state_n   = CLR_WAIT;
          end else if (step == STEP_LAST_FRAME) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            step_n  = step + 4'd1;
            state_n = ISSUE;
          end
        end
      end
      CLR_WAIT: begin
        if (counter == CLEAR_LAST) begin
          counter_n   = '0;
          init_done_n = 1'b1;
          value_q_n   = value;
          step_n      = STEP_FRAME;
          state_n     = ISSUE;
        end else begin
          counter_n = counter + 24'd1;
        end
      end
      IDLE: begin
        if (update || pending) begin
          value_q_n = value;
          pending_n = 1'b0;
          step_n    = STEP_FRAME;
          busy_n    = 1'b1;
          state_n   = ISSUE;
        end
      end
      default: begin
        state_n = POWER_WAIT;
      end
    endcase
  end

  assign lcd.lcd_data_in    = data_q;
  assign lcd.lcd_data_valid = valid_q;
  assign lcd.lcd_is_cmd     = is_cmd_q;
  assign lcd.lcd_clear      = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: a simple LCD driver model answers the
// handshake, the stimulus pushes expected bytes into a queue, and a monitor
// pops and compares on every strobe.
module tb_lcd_sequencer;

  localparam int INIT_D = 20;
  localparam int CLR_D  = 10;
  localparam int DRV_D  = 8;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        update = 1'b0;
  logic        busy;
  logic        init_done;
  logic        hold = 1'b0;
  logic        drv_ready;
  int          dcnt;

  lcd_sequencer_if lcd();

  lcd_sequencer #(.INIT_DELAY(INIT_D), .CLEAR_DELAY(CLR_D)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .update    (update),
    .busy      (busy),
    .init_done (init_done),
    .lcd       (lcd)
  );

  always #5 clk = ~clk;

  // Driver model: drops ready for DRV_D+1 cycles after each accepted strobe.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      drv_ready <= 1'b1;
      dcnt      <= 0;
    end else if (drv_ready && lcd.lcd_data_valid) begin
      drv_ready <= 1'b0;
      dcnt      <= DRV_D;
    end else if (!drv_ready) begin
      if (dcnt == 0) drv_ready <= 1'b1;
      else           dcnt      <= dcnt - 1;
    end
  end

  assign lcd.lcd_ready = drv_ready & ~hold;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int nbytes = 0;
  logic [8:0] exp_q[$];
  int         strobe_cycs[$];
  logic [8:0] last_exp = '0;
  string hexchars = "0123456789ABCDEF";
  string label    = "VAL:";
  logic [7:0] init_cmds[6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, init_cmds[i]});
  endtask

  task automatic push_frame(input logic [15:0] v);
    exp_q.push_back({1'b1, 8'h80});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, label[i]});
    for (int i = 3; i >= 0; i--) begin
      last_exp = {1'b0, hexchars[int'((v >> (4 * i)) & 16'hF)]};
      exp_q.push_back(last_exp);
    end
  endtask

  // Monitor: compare each strobed byte, enforce single-cycle strobes and
  // data/is_cmd stability until the driver is ready again.
  logic       prev_valid = 1'b0;
  logic       xfer = 1'b0;
  logic       seen_low = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      xfer       = 1'b0;
    end else begin
      if (lcd.lcd_data_valid) begin
        check("strobe_single_cycle", int'(prev_valid), 0);
        nbytes++;
        strobe_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h with is_cmd %0d, required no strobe",
                   lcd.lcd_data_in, lcd.lcd_is_cmd);
        end else begin
          check("byte", int'({lcd.lcd_is_cmd, lcd.lcd_data_in}), int'(exp_q.pop_front()));
        end
        held     = {lcd.lcd_is_cmd, lcd.lcd_data_in};
        xfer     = 1'b1;
        seen_low = 1'b0;
      end else if (xfer) begin
        check("byte_held", int'({lcd.lcd_is_cmd, lcd.lcd_data_in}), int'(held));
        if (!lcd.lcd_ready) seen_low = 1'b1;
        else if (seen_low) xfer = 1'b0;
      end
      prev_valid = lcd.lcd_data_valid;
    end
  end

  task automatic wait_bytes(input int target);
    int b = 0;
    while (nbytes < target && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    if (nbytes < target) check("timeout_bytes", nbytes, target);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    check("timeout_idle", int'(busy), 0);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},      int'(lcd.lcd_data_in), 0);
    check({tag, "_valid"},     int'(lcd.lcd_data_valid), 0);
    check({tag, "_is_cmd"},    int'(lcd.lcd_is_cmd), 1);
    check({tag, "_clear"},     int'(lcd.lcd_clear), 0);
    check({tag, "_busy"},      int'(busy), 1);
    check({tag, "_init_done"}, int'(init_done), 0);
  endtask

  // Assert reset (async), check outputs, then run init plus the automatic frame.
  task automatic reset_and_init(input logic [15:0] v, input string tag);
    int rel;
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    strobe_cycs.delete();
    nbytes = 0;
    value  = v;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs({tag, "_hold"});
    reset = 1'b1;
    rel   = cyc;
    push_init();
    push_frame(v);
    wait_bytes(15);
    if (strobe_cycs.size() >= 7) begin
      check("first_strobe_latency", strobe_cycs[0] - rel, INIT_D + 1);
      check("clear_gap_ok", int'((strobe_cycs[6] - strobe_cycs[5] - 1) >= CLR_D), 1);
    end else begin
      check("strobe_count_after_init", strobe_cycs.size(), 7);
    end
    wait_idle();
    check("init_done_after_init", int'(init_done), 1);
    check("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    int base;
    int sidx;
    int c;
    logic [15:0] v, v2;
    int extra;

    #2;
    reset_and_init(16'h3A9F, "reset");

    // Refresh from IDLE; a mid-frame value change must not leak in.
    @(negedge clk);
    value = 16'h00F0;
    base  = nbytes;
    push_frame(16'h00F0);
    pulse_update();
    check("busy_rises", int'(busy), 1);
    wait_bytes(base + 2);
    value = 16'hFFFF;
    wait_bytes(base + 9);
    wait_idle();

    // Three requests during a frame collapse into exactly one extra frame.
    @(negedge clk);
    value = 16'h5555;
    base  = nbytes;
    push_frame(16'h5555);
    pulse_update();
    wait_bytes(base + 2);
    repeat (3) begin
      pulse_update();
      repeat (2) @(negedge clk);
    end
    value = 16'h1234;
    push_frame(16'h1234);
    wait_bytes(base + 18);
    wait_idle();
    repeat (40) @(negedge clk);
    check("no_third_frame", nbytes, base + 18);
    check("idle_busy", int'(busy), 0);

    // Ready held low in ISSUE: no strobe, outputs frozen, strobe right after release.
    hold  = 1'b1;
    value = 16'hC0DE;
    base  = nbytes;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    push_frame(16'hC0DE);
    repeat (50) begin
      @(negedge clk);
      check("hold_no_strobe", int'(lcd.lcd_data_valid), 0);
    end
    sidx = strobe_cycs.size();
    hold = 1'b0;
    c    = cyc;
    wait_bytes(base + 1);
    if (strobe_cycs.size() > sidx) check("strobe_after_ready", strobe_cycs[sidx] - c, 1);
    wait_bytes(base + 9);
    wait_idle();

    // Randomised refreshes, some with coalesced mid-frame requests.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      v     = 16'($urandom);
      v2    = 16'($urandom);
      extra = int'($urandom_range(0, 3));
      value = v;
      base  = nbytes;
      push_frame(v);
      pulse_update();
      wait_bytes(base + 2);
      for (int j = 0; j < extra; j++) begin
        pulse_update();
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      if (extra > 0) begin
        value = v2;
        push_frame(v2);
        wait_bytes(base + 18);
      end else begin
        value = 16'($urandom);
        wait_bytes(base + 9);
      end
      wait_idle();
    end

    // Reset in the middle of the 'L' transfer (step 9), then full restart.
    @(negedge clk);
    value = 16'hBEEF;
    base  = nbytes;
    push_frame(16'hBEEF);
    pulse_update();
    wait_bytes(base + 4);
    reset_and_init(16'h0A5B, "midreset");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
